peripheral_showresult: RTL and testbench
========================================

Name: peripheral_showresult

Overview:
- Output-side counterpart of the byte-wise operand loader in the peripherals unit.
- The loader takes 32-bit operands in one byte per enter press; this block shows the captured operands and the result on the four 7-segment displays, one 16-bit halfword at a time.
- The user steps through halfwords with the same enter pushbutton.
- It sits between the operand/result registers (dataA, dataB, dataR) and the board displays disp3..disp0.

Parameters:
AUTO_CYCLES, 0, clock cycles between automatic view advances while showing; 0 disables auto-scroll.
CNT_W, 32, width of the auto-scroll counter; AUTO_CYCLES must fit in CNT_W bits.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
enter  input  1  raw pushbutton level, active-high, synchronous to clk, may stay high for many cycles.
loaddata  input  1  1 = loader owns the keypad (data entry mode); 0 = display mode.
inputdata_ready  input  1  1 = dataA, dataB and dataR are complete and valid.
dataA  input  32  operand A.
dataB  input  32  operand B.
dataR  input  32  result.
disp3  output  7  leftmost digit; active-low segments {g,f,e,d,c,b,a}.
disp2  output  7  digit 2.
disp1  output  7  digit 1.
disp0  output  7  rightmost digit.
view_sel  output  3  current view index 0..5.
showing  output  1  1 while in SHOW state.

Behaviour:
- Enter pulse: a registered copy of enter gives enter_pulse = enter & ~enter_q. One pulse per press however long the button is held; enter_q resets to 0.
- States: IDLE, SHOW.
- Reset (reset=0, any time, including mid-SHOW): state=IDLE, view_sel=0, showing=0, auto counter=0, snapshot registers=0, enter_q=0. disp3..disp0 = 7'b0111111 (dash) immediately.
- IDLE:
  - Displays show four dashes; showing=0; view_sel=0.
  - Transition to SHOW when loaddata==0 && inputdata_ready==1.
  - On that edge, snapshot dataA/dataB/dataR into internal 32-bit registers, set view_sel=0 and clear the auto counter.
  - An enter_pulse in the capture cycle is ignored.
- SHOW:
  - showing=1; displays are driven from the snapshot only, so later changes on dataA/B/R have no effect.
  - View map: 0=R[31:16], 1=R[15:0], 2=A[31:16], 3=A[15:0], 4=B[31:16], 5=B[15:0].
  - disp3 shows nibble [15:12] of the selected halfword, down to disp0 showing [3:0].
  - enter_pulse: view_sel <= (view_sel==5) ? 0 : view_sel+1, and the auto counter clears.
  - Auto-scroll (AUTO_CYCLES>0): the counter increments each cycle. When it reaches AUTO_CYCLES-1, the view advances with the same wrap rule and the counter clears.
  - If enter_pulse and auto expiry occur in the same cycle, only one advance happens.
  - Exit to IDLE when loaddata==1 or inputdata_ready==0. This exit has priority over any advance in the same cycle; view_sel clears to 0.
- Decoding: hex to active-low 7-seg, combinational from the registered view/snapshot, so displays change one cycle after the causing edge.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Re-entry: leaving SHOW and meeting the entry condition again takes a fresh snapshot.

Test Plan:
1. Reset held low with random inputs -> disp3..0 all 7'b0111111, showing=0, view_sel=0. Release reset with loaddata=1 -> outputs unchanged.
2. A=3F800000, B=A1BE867D, R=3F800000, loaddata=0, inputdata_ready=1 -> next cycle showing=1, view_sel=0, disp3..0 = 0110000, 0001110, 0000000, 1000000 ("3F80").
3. From step 2, enter held high for 5 cycles -> view_sel=1 exactly once, displays "0000". Six separate presses total -> views 1,2,3,4,5,0; view 4 shows "A1be" (0001000, 1111001, 0000011, 0000110).
4. In SHOW, change dataR to 12345678 -> displays unchanged. Raise loaddata -> next cycle IDLE with dashes; lower it again -> snapshot 12345678, view 0 shows "1234".
5. AUTO_CYCLES=4 -> view advances every 4 cycles. An enter press resets the interval; a press coinciding with expiry advances by one only.
6. Pull reset low mid-SHOW, asynchronously between clock edges -> dashes and showing=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/peripheral_showresult.sv
// -----------------------------------------------------------------------------
// peripheral_showresult
//
// Result viewer for the peripherals unit. Once the operand loader has released
// the keypad and all three words are valid, the block freezes a snapshot of
// operand A, operand B and the result, then shows one 16-bit halfword at a time
// on the four 7-segment digits. The enter pushbutton steps through the six
// halfwords (R hi, R lo, A hi, A lo, B hi, B lo); an optional auto-scroll timer
// advances the view on its own.
//
// Parameters
//   AUTO_CYCLES : cycles between automatic view advances in SHOW (0 = off)
//   CNT_W       : width of the auto-scroll counter
//
// Ports
//   clk             : system clock, rising edge
//   reset           : asynchronous active-low reset
//   enter           : raw pushbutton level, active-high, synchronous to clk
//   loaddata        : 1 = loader owns the keypad, 0 = display mode
//   inputdata_ready : 1 = dataA/dataB/dataR are complete and valid
//   dataA/B/R       : operand A, operand B, result (32 bits each)
//   disp3..disp0    : active-low segments {g,f,e,d,c,b,a}, disp3 leftmost
//   view_sel        : current halfword index 0..5
//   showing         : 1 while in SHOW
// -----------------------------------------------------------------------------
module peripheral_showresult #(
  parameter int unsigned AUTO_CYCLES = 32'd0,
  parameter int unsigned CNT_W       = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        loaddata,
  input  logic        inputdata_ready,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] dataR,
  output logic [6:0]  disp3,
  output logic [6:0]  disp2,
  output logic [6:0]  disp1,
  output logic [6:0]  disp0,
  output logic [2:0]  view_sel,
  output logic        showing
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0]        SEG_DASH    = 7'b0111111;
  localparam logic [2:0]        VIEW_LAST   = 3'd5;
  localparam bit                AUTO_EN     = (AUTO_CYCLES > 32'd0);
  localparam int unsigned       AUTO_LAST   = AUTO_EN ? (AUTO_CYCLES - 32'd1) : 32'd0;
  localparam logic [CNT_W-1:0]  AUTO_LAST_C = CNT_W'(AUTO_LAST);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(32'd1);

  // Hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] seg;
    case (h)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       view_q, view_d;
  logic             show_q, show_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      snap_a_q, snap_a_d;
  logic [31:0]      snap_b_q, snap_b_d;
  logic [31:0]      snap_r_q, snap_r_d;
  logic             enter_q;

  logic             enter_pulse_s;
  logic             auto_expire_s;
  logic [2:0]       view_next_s;
  logic [15:0]      halfword_s;

  assign enter_pulse_s = enter & ~enter_q;
  // The counter sits at zero whenever auto-scroll is disabled, so gating with
  // AUTO_EN keeps a zero-cycle setting from firing every cycle.
  assign auto_expire_s = AUTO_EN && (cnt_q == AUTO_LAST_C);
  assign view_next_s   = (view_q == VIEW_LAST) ? 3'd0 : (view_q + 3'd1);

  // Next-state logic for the viewer FSM, view index, timer and snapshot.
  always_comb begin
    state_d  = state_q;
    view_d   = view_q;
    show_d   = show_q;
    cnt_d    = cnt_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    snap_r_d = snap_r_q;
    case (state_q)
      IDLE: begin
        view_d = 3'd0;
        cnt_d  = '0;
        if (!loaddata && inputdata_ready) begin
          // Capture edge: an enter pulse here is deliberately not acted on.
          state_d  = SHOW;
          show_d   = 1'b1;
          snap_a_d = dataA;
          snap_b_d = dataB;
          snap_r_d = dataR;
        end else begin
          show_d = 1'b0;
        end
      end
      SHOW: begin
        if (loaddata || !inputdata_ready) begin
          // Leaving wins over any advance requested in the same cycle.
          state_d = IDLE;
          show_d  = 1'b0;
          view_d  = 3'd0;
          cnt_d   = '0;
        end else if (enter_pulse_s || auto_expire_s) begin
          // Press and timer expiry together still produce a single step.
          view_d = view_next_s;
          cnt_d  = '0;
        end else if (AUTO_EN) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        show_d  = 1'b0;
        view_d  = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers, including the enter edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      view_q   <= 3'd0;
      show_q   <= 1'b0;
      cnt_q    <= '0;
      snap_a_q <= 32'd0;
      snap_b_q <= 32'd0;
      snap_r_q <= 32'd0;
      enter_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      view_q   <= view_d;
      show_q   <= show_d;
      cnt_q    <= cnt_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      snap_r_q <= snap_r_d;
      enter_q  <= enter;
    end
  end

  // Select the halfword addressed by the current view from the snapshot.
  always_comb begin
    case (view_q)
      3'd0:    halfword_s = snap_r_q[31:16];
      3'd1:    halfword_s = snap_r_q[15:0];
      3'd2:    halfword_s = snap_a_q[31:16];
      3'd3:    halfword_s = snap_a_q[15:0];
      3'd4:    halfword_s = snap_b_q[31:16];
      3'd5:    halfword_s = snap_b_q[15:0];
      default: halfword_s = 16'h0000;
    endcase
  end

  // Digit decode; dashes whenever not showing, so reset blanks them at once.
  always_comb begin
    if (show_q) begin
      disp3 = hex7(halfword_s[15:12]);
      disp2 = hex7(halfword_s[11:8]);
      disp1 = hex7(halfword_s[7:4]);
      disp0 = hex7(halfword_s[3:0]);
    end else begin
      disp3 = SEG_DASH;
      disp2 = SEG_DASH;
      disp1 = SEG_DASH;
      disp0 = SEG_DASH;
    end
  end

  assign view_sel = view_q;
  assign showing  = show_q;

endmodule

// File: tb/tb_peripheral_showresult.sv
module tb_peripheral_showresult;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic        loaddata;
  logic        inputdata_ready;
  logic [31:0] dataA, dataB, dataR;

  logic [6:0]  disp3, disp2, disp1, disp0;
  logic [2:0]  view_sel;
  logic        showing;

  logic [6:0]  a_disp3, a_disp2, a_disp1, a_disp0;
  logic [2:0]  a_view_sel;
  logic        a_showing;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic [31:0] s_a, s_b, s_r;
  logic [6:0]  seg_tab [16];
  localparam logic [6:0] DASH = 7'b0111111;

  peripheral_showresult dut (
    .clk(clk), .reset(reset), .enter(enter), .loaddata(loaddata),
    .inputdata_ready(inputdata_ready), .dataA(dataA), .dataB(dataB), .dataR(dataR),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .view_sel(view_sel), .showing(showing)
  );

  peripheral_showresult #(.AUTO_CYCLES(32'd4), .CNT_W(32'd8)) dut_auto (
    .clk(clk), .reset(reset), .enter(enter), .loaddata(loaddata),
    .inputdata_ready(inputdata_ready), .dataA(dataA), .dataB(dataB), .dataR(dataR),
    .disp3(a_disp3), .disp2(a_disp2), .disp1(a_disp1), .disp0(a_disp0),
    .view_sel(a_view_sel), .showing(a_showing)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_vec(input logic show, input logic [2:0] v);
    logic [15:0] hw;
    case (v)
      3'd0:    hw = s_r[31:16];
      3'd1:    hw = s_r[15:0];
      3'd2:    hw = s_a[31:16];
      3'd3:    hw = s_a[15:0];
      3'd4:    hw = s_b[31:16];
      default: hw = s_b[15:0];
    endcase
    if (show)
      return {1'b1, v, seg_tab[hw[15:12]], seg_tab[hw[11:8]], seg_tab[hw[7:4]], seg_tab[hw[3:0]]};
    else
      return {1'b0, 3'd0, DASH, DASH, DASH, DASH};
  endfunction

  function automatic logic [31:0] obs_main();
    return {showing, view_sel, disp3, disp2, disp1, disp0};
  endfunction

  function automatic logic [31:0] obs_auto();
    return {a_showing, a_view_sel, a_disp3, a_disp2, a_disp1, a_disp0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dataA = $urandom; dataB = $urandom; dataR = $urandom;
      enter = 1'($urandom_range(0, 1));
      loaddata = 1'($urandom_range(0, 1));
      inputdata_ready = 1'($urandom_range(0, 1));
      sb.push_back(exp_vec(1'b0, 3'd0));
      step();
      e = sb.pop_front(); g = obs_main(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset_hold: got %h expected %h", g, e); end
    end
    enter = 1'b0; loaddata = 1'b1; inputdata_ready = 1'b1;
    step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exp_vec(1'b0, 3'd0));
      step();
      e = sb.pop_front(); g = obs_main(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset_release: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_capture();
    logic [31:0] e, g;
    dataA = 32'h3F800000; dataB = 32'hA1BE867D; dataR = 32'h3F800000;
    loaddata = 1'b0; inputdata_ready = 1'b1;
    s_a = dataA; s_b = dataB; s_r = dataR;
    sb.push_back({1'b1, 3'd0, 7'b0110000, 7'b0001110, 7'b0000000, 7'b1000000});
    sb.push_back(exp_vec(1'b1, 3'd0));
    step();
    g = obs_main();
    e = sb.pop_front(); checks++;
    if (g !== e) begin failures++; $display("FAIL capture_3F80: got %h expected %h", g, e); end
    e = sb.pop_front(); checks++;
    if (g !== e) begin failures++; $display("FAIL capture_model: got %h expected %h", g, e); end
  endtask

  task automatic test_hold_and_step();
    logic [31:0] e, g;
    logic [2:0]  v;
    enter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(exp_vec(1'b1, 3'd1));
      step();
      e = sb.pop_front(); g = obs_main(); checks++;
      if (g !== e) begin failures++; $display("FAIL enter_held cyc%0d: got %h expected %h", i, g, e); end
    end
    enter = 1'b0;
    sb.push_back({1'b1, 3'd1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL view1_0000: got %h expected %h", g, e); end
    for (int k = 2; k <= 6; k++) begin
      v = 3'(k % 6);
      enter = 1'b1;
      sb.push_back(exp_vec(1'b1, v));
      if (v == 3'd4) sb.push_back({1'b1, 3'd4, 7'b0001000, 7'b1111001, 7'b0000011, 7'b0000110});
      step();
      g = obs_main();
      e = sb.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL press_view%0d: got %h expected %h", v, g, e); end
      if (v == 3'd4) begin
        e = sb.pop_front(); checks++;
        if (g !== e) begin failures++; $display("FAIL view4_A1be: got %h expected %h", g, e); end
      end
      enter = 1'b0;
      sb.push_back(exp_vec(1'b1, v));
      step();
      e = sb.pop_front(); g = obs_main(); checks++;
      if (g !== e) begin failures++; $display("FAIL release_view%0d: got %h expected %h", v, g, e); end
    end
  endtask

  task automatic test_freeze_reentry();
    logic [31:0] e, g;
    dataR = 32'h12345678;
    sb.push_back(exp_vec(1'b1, 3'd0));
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL frozen_snapshot: got %h expected %h", g, e); end
    loaddata = 1'b1;
    sb.push_back(exp_vec(1'b0, 3'd0));
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL exit_on_loaddata: got %h expected %h", g, e); end
    // Re-entry with an enter edge in the capture cycle: the press must be ignored.
    loaddata = 1'b0; enter = 1'b1;
    s_r = dataR;
    sb.push_back({1'b1, 3'd0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    sb.push_back(exp_vec(1'b1, 3'd0));
    step();
    g = obs_main();
    e = sb.pop_front(); checks++;
    if (g !== e) begin failures++; $display("FAIL reentry_1234: got %h expected %h", g, e); end
    e = sb.pop_front(); checks++;
    if (g !== e) begin failures++; $display("FAIL capture_press_ignored: got %h expected %h", g, e); end
    enter = 1'b0;
    sb.push_back(exp_vec(1'b1, 3'd0));
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL reentry_hold: got %h expected %h", g, e); end
    inputdata_ready = 1'b0;
    sb.push_back(exp_vec(1'b0, 3'd0));
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL exit_on_not_ready: got %h expected %h", g, e); end
    inputdata_ready = 1'b1;
    step();
  endtask

  task automatic test_auto_scroll();
    logic [31:0] e, g;
    logic        en_seq [19];
    logic [2:0]  v_seq  [19];
    en_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_seq  = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
               3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    loaddata = 1'b1; enter = 1'b0;
    step();
    loaddata = 1'b0;
    s_a = dataA; s_b = dataB; s_r = dataR;
    sb.push_back(exp_vec(1'b1, 3'd0));
    step();
    e = sb.pop_front(); g = obs_auto(); checks++;
    if (g !== e) begin failures++; $display("FAIL auto_capture: got %h expected %h", g, e); end
    for (int i = 0; i < 19; i++) begin
      enter = en_seq[i];
      sb.push_back(exp_vec(1'b1, v_seq[i]));
      step();
      e = sb.pop_front(); g = obs_auto(); checks++;
      if (g !== e) begin failures++; $display("FAIL auto_edge%0d: got %h expected %h", i, g, e); end
    end
    enter = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] e, g;
    step();
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(exp_vec(1'b0, 3'd0));
    sb.push_back(exp_vec(1'b0, 3'd0));
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL async_reset_main: got %h expected %h", g, e); end
    e = sb.pop_front(); g = obs_auto(); checks++;
    if (g !== e) begin failures++; $display("FAIL async_reset_auto: got %h expected %h", g, e); end
    sb.push_back(exp_vec(1'b0, 3'd0));
    step();
    e = sb.pop_front(); g = obs_main(); checks++;
    if (g !== e) begin failures++; $display("FAIL reset_held_edge: got %h expected %h", g, e); end
    loaddata = 1'b1;
    reset = 1'b1;
    step();
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    s_a = 32'd0; s_b = 32'd0; s_r = 32'd0;
    reset = 1'b0; enter = 1'b0; loaddata = 1'b1; inputdata_ready = 1'b0;
    dataA = 32'd0; dataB = 32'd0; dataR = 32'd0;
    test_reset();
    test_capture();
    test_hold_and_step();
    test_freeze_reentry();
    test_auto_scroll();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
